// File: rtl/sig_rom_arbiter_pkg.sv
// Shared definitions for the sigmoid ROM arbiter: FSM encoding, ROM latency
// and the round-robin pointer wrap helper.
package sig_rom_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Cycles between presenting rom_x and rom_data carrying its result.
    localparam int ROM_LATENCY = 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sig_rom_arbiter_if.sv
// Request/ROM/response bundle between the requesters and the shared-ROM arbiter.
interface sig_rom_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int inWidth   = 10,
    parameter int dataWidth = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*inWidth-1:0] req_x;
    logic [NUM_REQ-1:0]         req_ready;
    logic [inWidth-1:0]         rom_x;
    logic [dataWidth-1:0]       rom_data;
    logic                       rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [dataWidth-1:0]       rsp_data;

    modport master (
        output req_valid, req_x, rom_data,
        input  req_ready, rom_x, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_x, rom_data,
        output req_ready, rom_x, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/sig_rom_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int IDW = $clog2(NUM_REQ);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one sigmoid ROM among NUM_REQ requesters.
// Optional per-requester lookup counters when SIGARB_STATS_EN is defined.
module sig_rom_arbiter
    import sig_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int inWidth   = 10,
    parameter int dataWidth = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    sig_rom_arbiter_if.slave bus,
    output logic idle
`ifdef SIGARB_STATS_EN
    ,output logic [NUM_REQ*16-1:0] lookup_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int LAST = ROM_LATENCY - 1;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [IDW-1:0]       ptr;
    logic [NUM_REQ-1:0]   grant_req;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 hs;
    logic [ROM_LATENCY-1:0] s1_valid;
    logic [IDW-1:0]       s1_id [ROM_LATENCY];
    logic                 rsp_valid_q;
    logic [IDW-1:0]       rsp_id_q;
    logic [dataWidth-1:0] rsp_data_q;

    // Grants are also suppressed the cycle enable drops, so draining starts at once.
    assign grant_req = (state == ST_RUN && enable && !rst) ? bus.req_valid : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (grant_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign hs            = |grant;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    always_comb begin
        bus.rom_x = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bus.rom_x = bus.req_x[i*inWidth +: inWidth];
            end
        end
    end

    // Leave DRAIN as soon as the ROM stage is empty: the output stage then
    // empties on the same edge, so idle rises right after the last response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_RUN;
            ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                end else if (s1_valid == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            s1_valid    <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) s1_id[k] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ptr <= IDW'(wrap_inc(int'(grant_idx), NUM_REQ));
            end
            s1_valid[0] <= hs;
            s1_id[0]    <= grant_idx;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                s1_valid[k] <= s1_valid[k-1];
                s1_id[k]    <= s1_id[k-1];
            end
            rsp_valid_q <= s1_valid[LAST];
            if (s1_valid[LAST]) begin
                rsp_id_q   <= s1_id[LAST];
                rsp_data_q <= bus.rom_data;
            end
        end
    end

    assign idle = (state == ST_IDLE) && (s1_valid == '0) && !rsp_valid_q;

`ifdef SIGARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid_q && rsp_id_q == IDW'(i) && cnt[i] != 16'hFFFF) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign lookup_count[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Self-checking bench for sig_rom_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_sig_rom_arbiter;

    localparam int NR = 4;
    localparam int IW = 10;
    localparam int DW = 16;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic idle;
`ifdef SIGARB_STATS_EN
    logic [NR*16-1:0] lookup_count;
`endif

    always #5 clk = ~clk;

    sig_rom_arbiter_if #(.NUM_REQ(NR), .inWidth(IW), .dataWidth(DW)) bus ();

    sig_rom_arbiter #(.NUM_REQ(NR), .inWidth(IW), .dataWidth(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .idle   (idle)
`ifdef SIGARB_STATS_EN
        ,.lookup_count (lookup_count)
`endif
    );

    function automatic logic [15:0] rom_model(input logic [9:0] x);
        return 16'(int'(x) * 97 + 13) ^ 16'hA5C3;
    endfunction

    // One-cycle ROM standing in for the real sigmoid table.
    always @(posedge clk) bus.rom_data <= rom_model(bus.rom_x);

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } pend_t;

    int          mMode = M_IDLE;
    int          mPtr = 0;
    int          cyc = 0;
    pend_t       pend[$];
    int          lastId = 0;
    logic [15:0] lastData = '0;
    logic        cRst, cEn;
    int          eGrant;
    logic [3:0]  eReady;
    logic [9:0]  eRomX;
    logic        eRspValid;
    logic [1:0]  eRspId;
    logic [15:0] eRspData;
    logic        eIdle;
    bit          evaluated = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [9:0] xOf(input int i);
        return bus.req_x[i*IW +: IW];
    endfunction

    function automatic void model_eval();
        cRst   = rst;
        cEn    = enable;
        eGrant = -1;
        if (mMode == M_RUN && cEn && !cRst) begin
            for (int k = 0; k < NR; k++) begin
                if (eGrant < 0 && bus.req_valid[(mPtr + k) % NR]) eGrant = (mPtr + k) % NR;
            end
        end
        eReady    = (eGrant >= 0) ? 4'(1 << eGrant) : 4'b0000;
        eRomX     = (eGrant >= 0) ? xOf(eGrant) : 10'h000;
        eRspValid = (pend.size() > 0) && (pend[0].due == cyc);
        if (eRspValid) begin
            eRspId   = 2'(pend[0].id);
            eRspData = pend[0].data;
        end else begin
            eRspId   = 2'(lastId);
            eRspData = lastData;
        end
        eIdle = (mMode == M_IDLE) && (pend.size() == 0);
    endfunction

    function automatic void model_commit();
        if (cRst) begin
            mMode = M_IDLE;
            mPtr = 0;
            pend.delete();
            lastId = 0;
            lastData = '0;
        end else begin
            if (eRspValid) begin
                lastId = pend[0].id;
                lastData = pend[0].data;
                void'(pend.pop_front());
            end
            if (eGrant >= 0) begin
                pend.push_back('{eGrant, rom_model(eRomX), cyc + 2});
                mPtr = (eGrant + 1) % NR;
            end
            case (mMode)
                M_IDLE:  if (cEn) mMode = M_RUN;
                M_RUN:   if (!cEn) mMode = M_DRAIN;
                default: begin
                    if (cEn) mMode = M_RUN;
                    else if (pend.size() == 0) mMode = M_IDLE;
                end
            endcase
        end
        cyc++;
    endfunction

    task automatic drive(input logic r, input logic en, input logic [3:0] v, input logic [39:0] x);
        if (evaluated) model_commit();
        @(negedge clk);
        rst = r;
        enable = en;
        bus.req_valid = v;
        bus.req_x = x;
        #1;
        model_eval();
        evaluated = 1;
    endtask

    function automatic logic [39:0] rndx();
        return 40'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        drive(1, 0, 4'b0000, '0);
        drive(1, 0, 4'b0000, '0);
        drive(0, 0, 4'b0000, '0);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_data got=%h exp=0000", bus.rsp_data); end
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_single();
        drive(0, 1, 4'b0001, '0);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_idle_ready got=%b exp=0000", bus.req_ready); end
        drive(0, 1, 4'b0001, '0);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got=%b exp=0001", bus.req_ready); end
        checks++; if (bus.rom_x !== 10'h000) begin errors++; $display("[TB] FAIL single_rom_x got=%h exp=000", bus.rom_x); end
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 4'b0000, '0);
            checks++; if (bus.rsp_valid !== (k == 2)) begin errors++; $display("[TB] FAIL single_rsp_valid t+%0d got=%b exp=%b", k, bus.rsp_valid, k == 2); end
            if (k == 2) begin
                checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); end
                checks++; if (bus.rsp_data !== rom_model(10'h000)) begin errors++; $display("[TB] FAIL single_rsp_data got=%h exp=%h", bus.rsp_data, rom_model(10'h000)); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [39:0] xs [10];
        drive(1, 0, 4'b0000, '0);
        drive(0, 1, 4'b0000, '0);
        for (int c = 0; c < 10; c++) begin
            xs[c] = rndx();
            drive(0, 1, (c < 8) ? 4'b1111 : 4'b0000, xs[c]);
            if (c < 8) begin
                checks++; if (bus.req_ready !== 4'(1 << (c % 4))) begin errors++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4))); end
                checks++; if (bus.rom_x !== xs[c][(c % 4)*IW +: IW]) begin errors++; $display("[TB] FAIL rr_rom_x c=%0d got=%h exp=%h", c, bus.rom_x, xs[c][(c % 4)*IW +: IW]); end
            end
            if (c >= 2) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((c - 2) % 4)) begin errors++; $display("[TB] FAIL rr_rsp c=%0d got=%b/%0d exp=1/%0d", c, bus.rsp_valid, bus.rsp_id, (c - 2) % 4); end
                checks++; if (bus.rsp_data !== rom_model(xs[c-2][((c - 2) % 4)*IW +: IW])) begin errors++; $display("[TB] FAIL rr_rsp_data c=%0d got=%h", c, bus.rsp_data); end
            end
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 4'b0000, '0);
        drive(0, 1, 4'b0000, '0);
        drive(0, 1, 4'b0001, rndx());
        drive(0, 1, 4'b0010, rndx());
        drive(0, 1, 4'b1010, rndx());
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first got=%b exp=1000", bus.req_ready); end
        drive(0, 1, 4'b1010, rndx());
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_second got=%b exp=0010", bus.req_ready); end
        drive(0, 1, 4'b1111, rndx());
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_ptr got=%b exp=0100", bus.req_ready); end
    endtask

    task automatic test_drain();
        drive(1, 0, 4'b0000, '0);
        drive(0, 1, 4'b0000, '0);
        drive(0, 1, 4'b0001, rndx());
        drive(0, 1, 4'b0010, rndx());
        drive(0, 0, 4'b1111, rndx());
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drain_ready_t2 got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL drain_rsp_t2 got=%b/%0d exp=1/0", bus.rsp_valid, bus.rsp_id); end
        drive(0, 0, 4'b1111, rndx());
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL drain_rsp_t3 got=%b/%0d exp=1/1", bus.rsp_valid, bus.rsp_id); end
        checks++; if (idle !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drain_t3 idle/ready got=%b/%b exp=0/0000", idle, bus.req_ready); end
        drive(0, 0, 4'b1111, rndx());
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL drain_idle_t4 got=%b exp=1", idle); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_rsp_t4 got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 4'b0000, '0);
        drive(0, 1, 4'b0000, '0);
        drive(0, 1, 4'b0001, rndx());
        drive(1, 1, 4'b0000, '0);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_ready got=%b exp=0000", bus.req_ready); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 4'b0000, '0);
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rsp k=%0d got=%b exp=0", k, bus.rsp_valid); end
            checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_idle k=%0d got=%b exp=1", k, idle); end
        end
        drive(0, 1, 4'b0000, '0);
        drive(0, 1, 4'b1111, rndx());
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rstmid_ptr got=%b exp=0001", bus.req_ready); end
    endtask

    task automatic test_random();
        logic en = 1'b1;
        drive(1, 0, 4'b0000, '0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) en = !en;
            drive(($urandom_range(0, 99) == 0), en, 4'($urandom()), rndx());
            checks++; if (bus.req_ready !== eReady) begin errors++; $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, eReady); end
            checks++; if (bus.rom_x !== eRomX) begin errors++; $display("[TB] FAIL rnd_rom_x c=%0d got=%h exp=%h", c, bus.rom_x, eRomX); end
            checks++; if (bus.rsp_valid !== eRspValid) begin errors++; $display("[TB] FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, eRspValid); end
            checks++; if (bus.rsp_id !== eRspId) begin errors++; $display("[TB] FAIL rnd_rsp_id c=%0d got=%0d exp=%0d", c, bus.rsp_id, eRspId); end
            checks++; if (bus.rsp_data !== eRspData) begin errors++; $display("[TB] FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, bus.rsp_data, eRspData); end
            checks++; if (idle !== eIdle) begin errors++; $display("[TB] FAIL rnd_idle c=%0d got=%b exp=%b", c, idle, eIdle); end
        end
    endtask

`ifdef SIGARB_STATS_EN
    task automatic test_stats();
        drive(1, 0, 4'b0000, '0);
        drive(0, 1, 4'b0000, '0);
        for (int k = 0; k < 5; k++) drive(0, 1, 4'b0100, rndx());
        for (int k = 0; k < 3; k++) drive(0, 0, 4'b0000, '0);
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (lookup_count[i*16 +: 16] !== ((i == 2) ? 16'd5 : 16'd0)) begin
                errors++;
                $display("[TB] FAIL stats_count[%0d] got=%0d exp=%0d", i, lookup_count[i*16 +: 16], (i == 2) ? 5 : 0);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.req_x = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drain();
        test_reset_mid();
        test_random();
`ifdef SIGARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sig_rom_arbiter.md
SIG_ROM_ARBITER -- requirements
Module: sig_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sigmoid ROM (2..16).
REQ-002 Parameter inWidth, default 10, ROM address/input width.
REQ-003 Parameter dataWidth, default 16, ROM output width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high permits new grants; low requests a drain to idle.
REQ-007 req_valid  input  NUM_REQ  per-requester lookup request.
REQ-008 req_x  input  NUM_REQ*inWidth  packed signed inputs; requester i occupies bits [i*inWidth +: inWidth].
REQ-009 req_ready  output  NUM_REQ  one-hot grant; handshake is req_valid[i] && req_ready[i].
REQ-010 rom_x  output  inWidth  address to shared ROM, driven combinationally from the granted req_x.
REQ-011 rom_data  input  dataWidth  ROM result for the rom_x presented one cycle earlier.
REQ-012 rsp_valid  output  1  one-cycle pulse per completed lookup; no backpressure.
REQ-013 rsp_id  output  $clog2(NUM_REQ)  index of requester owning rsp_data.
REQ-014 rsp_data  output  dataWidth  registered ROM result.
REQ-015 idle  output  1  high in IDLE state with no lookups in flight.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when both pipeline stages empty; DRAIN->RUN when enable=1.
REQ-017 Grants issue only in RUN, at most one per cycle; req_ready all-zero in IDLE and DRAIN.
REQ-018 Round-robin: grant lowest index i >= ptr (wrapping modulo NUM_REQ) with req_valid[i]=1; ptr updates to (i+1) mod NUM_REQ only on a grant.
REQ-019 req_ready shall not depend on req_ready of any other cycle combinationally beyond ptr, state and req_valid.
REQ-020 rom_x = granted req_x when a grant occurs, else all-zero.
REQ-021 Stage 1 register captures {valid, id} of the grant; stage 2 registers rom_data, id, valid into rsp_data, rsp_id, rsp_valid.
REQ-022 Latency: handshake in cycle t -> rsp_valid=1 in cycle t+2; sustained throughput one lookup per cycle.
REQ-023 Responses leave in grant order; no lookup is dropped or duplicated.
REQ-024 enable falling with lookups in flight: in-flight responses still delivered; idle rises the cycle after the last rsp_valid.
REQ-025 Single requester holding req_valid continuously is granted every cycle; with all valid, each requester granted once per NUM_REQ cycles.
REQ-026 rsp_data/rsp_id hold last value when rsp_valid=0.

Reset
REQ-027 During rst: state IDLE, ptr 0, both stages invalid, rsp_valid 0, rsp_id 0, rsp_data 0, req_ready 0, idle 1 after the reset edge.
REQ-028 Reset mid-operation discards all in-flight lookups; no rsp_valid in the cycle after reset deasserts.

Configuration
REQ-029 Macro SIGARB_STATS_EN defined: output lookup_count (NUM_REQ*16 bits), per-requester 16-bit counters incremented on each rsp_valid for rsp_id, saturating at 16'hFFFF, cleared by rst.
REQ-030 SIGARB_STATS_EN undefined: lookup_count port and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package holds FSM state encoding (IDLE, RUN, DRAIN) and the ROM latency constant (1).
REQ-032 Round-robin grant logic is a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index); the ROM is instantiated outside this block.

Verification
REQ-033 Reset, enable=1, req_valid=4'b0001, req_x[0]=10'h000 -> req_ready=4'b0001 same cycle, rom_x=0, rsp_valid at t+2 with rsp_id=0, rsp_data=ROM model[x].
REQ-034 All four valid for 8 cycles from ptr=0 -> grant sequence 0,1,2,3,0,1,2,3; rsp_id sequence identical, delayed 2 cycles.
REQ-035 req_valid=4'b1010, ptr=2 -> grant 3 then 1; ptr ends at 2.
REQ-036 Grants in cycles t and t+1, enable=0 at t+2 -> rsp_valid at t+2, t+3; no grant from t+2; idle=1 at t+4.
REQ-037 rst asserted one cycle after a grant -> no rsp_valid afterwards; idle=1, ptr=0.
REQ-038 SIGARB_STATS_EN defined, requester 2 granted 5 times -> lookup_count[2]=5, others 0; preloaded at 16'hFFFF stays 16'hFFFF.
